// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | mem_port_arbiter_if                                                    |
// | Fetch, data and memory-side signals of the unified memory port.        |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ready;
  logic [DATA_W-1:0] if_rdata;
  logic              d_rd_en;
  logic              d_wr_en;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ready;
  logic [DATA_W-1:0] d_rdata;
  logic              if_stall;
  logic              d_stall;
  logic              mem_en;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Pipeline and memory side
  modport master (
    output if_req, if_addr, d_rd_en, d_wr_en, d_addr, d_wdata, mem_rdata,
    input  if_ready, if_rdata, d_ready, d_rdata, if_stall, d_stall,
           mem_en, mem_wr, mem_addr, mem_wdata
  );

  // Arbiter side
  modport slave (
    input  if_req, if_addr, d_rd_en, d_wr_en, d_addr, d_wdata, mem_rdata,
    output if_ready, if_rdata, d_ready, d_rdata, if_stall, d_stall,
           mem_en, mem_wr, mem_addr, mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | mem_port_arbiter                                                       |
// | Shares one fixed-latency memory between fetch and data, data first.    |
// | Optional macro ARB_STARVE_GUARD_EN: lets fetch win after STARVE_MAX    |
// | consecutive data grants made while fetch was waiting.                  |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module mem_port_arbiter #(
  parameter int MEM_LAT    = 4,
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int STARVE_MAX = 2
) (
  input logic               clk,
  input logic               rst_n,
  mem_port_arbiter_if.slave bus
);

  if (MEM_LAT < 1 || MEM_LAT > 15 || STARVE_MAX < 1 || STARVE_MAX > 7) begin : g_param_check
    $error("mem_port_arbiter: MEM_LAT or STARVE_MAX out of range");
  end

  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DATA = 2'd2
  } owner_t;

  state_t            r_state;
  state_t            w_next;
  owner_t            r_owner;
  logic              r_wr;
  logic [3:0]        r_cnt;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_d_rdata;
  logic              r_if_ready;
  logic              r_d_ready;
  logic              w_data_req;
  logic              w_grant_if;
  logic              w_grant_d;

`ifdef ARB_STARVE_GUARD_EN
  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);
  logic [2:0] r_starve;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_data_req = bus.d_rd_en | bus.d_wr_en;
`ifdef ARB_STARVE_GUARD_EN
    w_grant_if = bus.if_req & (~w_data_req | (r_starve == STARVE_LIM));
`else
    w_grant_if = bus.if_req & ~w_data_req;
`endif
    w_grant_d  = w_data_req & ~w_grant_if;
    w_next     = r_state;
    case (r_state)
      S_IDLE:  if (w_grant_d | w_grant_if) w_next = S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  if (r_cnt == 4'd0) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner     <= OWN_NONE;
      r_wr        <= 1'b0;
      r_cnt       <= 4'd0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
      r_if_ready  <= 1'b0;
      r_d_ready   <= 1'b0;
    end else begin
      r_if_ready <= 1'b0;
      r_d_ready  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant_d) begin
            r_owner     <= OWN_DATA;
            r_wr        <= bus.d_wr_en;
            r_mem_addr  <= bus.d_addr;
            r_mem_wdata <= bus.d_wdata;
          end else if (w_grant_if) begin
            r_owner    <= OWN_IF;
            r_wr       <= 1'b0;
            r_mem_addr <= bus.if_addr;
          end
        end
        S_ISSUE: r_cnt <= LAT_M1;
        S_WAIT: begin
          if (r_cnt == 4'd0) begin
            // Memory data is valid this cycle; ready goes out in DONE.
            if (r_owner == OWN_IF) begin
              r_if_ready <= 1'b1;
              r_if_rdata <= bus.mem_rdata;
            end else begin
              r_d_ready <= 1'b1;
              if (!r_wr) r_d_rdata <= bus.mem_rdata;
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_DONE:  r_owner <= OWN_NONE;
        default: r_owner <= OWN_NONE;
      endcase
    end
  end

`ifdef ARB_STARVE_GUARD_EN
  // Counts data grants that overtook a waiting fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve <= 3'd0;
    end else if (r_state == S_IDLE) begin
      if (w_grant_if)     r_starve <= 3'd0;
      else if (w_grant_d) r_starve <= bus.if_req ? r_starve + 3'd1 : 3'd0;
    end
  end
`endif

  assign bus.mem_en    = (r_state == S_ISSUE);
  assign bus.mem_wr    = (r_state == S_ISSUE) & r_wr;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.if_ready  = r_if_ready;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.d_ready   = r_d_ready;
  assign bus.d_rdata   = r_d_rdata;
  assign bus.if_stall  = bus.if_req & ~r_if_ready;
  assign bus.d_stall   = (bus.d_rd_en | bus.d_wr_en) & ~r_d_ready;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_mem_port_arbiter                                                    |
// | Directed checks of mem_port_arbiter with a fixed-latency memory model. |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_mem_port_arbiter;
  localparam int MEM_LAT = 4;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  int   lat_cnt;
  logic [15:0] ret_val;

  mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  mem_port_arbiter #(
    .MEM_LAT(MEM_LAT), .ADDR_W(16), .DATA_W(16), .STARVE_MAX(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mem_val(input logic [15:0] a);
    case (a)
      16'h0010: mem_val = 16'hA123;
      16'h0200: mem_val = 16'hBEEF;
      default:  mem_val = a ^ 16'h5A5A;
    endcase
  endfunction

  // Memory returns data exactly MEM_LAT cycles after the mem_en cycle, junk otherwise.
  always @(posedge clk) begin
    if (bus.mem_en) begin
      lat_cnt <= MEM_LAT;
      ret_val <= mem_val(bus.mem_addr);
    end else if (lat_cnt != 0) begin
      lat_cnt <= lat_cnt - 1;
    end
  end
  assign bus.mem_rdata = (lat_cnt == 1) ? ret_val : 16'hDEAD;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.if_req = 0; bus.if_addr = 0; bus.d_rd_en = 0; bus.d_wr_en = 0;
    bus.d_addr = 0; bus.d_wdata = 0;
    tick(); tick();
    n_cmp++;
    if ({bus.if_ready, bus.d_ready, bus.mem_en, bus.mem_wr, bus.if_stall, bus.d_stall} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_bits got %b exp 000000",
               {bus.if_ready, bus.d_ready, bus.mem_en, bus.mem_wr, bus.if_stall, bus.d_stall});
    end
    n_cmp++;
    if ({bus.mem_addr, bus.mem_wdata, bus.if_rdata, bus.d_rdata} !== 64'h0) begin
      n_err++;
      $display("FAIL reset_words got %h exp 0",
               {bus.mem_addr, bus.mem_wdata, bus.if_rdata, bus.d_rdata});
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fetch();
    logic [2:0] exp;
    for (int c = 0; c <= 6; c++) begin
      if (c == 0) begin bus.if_req = 1; bus.if_addr = 16'h0010; end
      #1;
      exp = {(c <= 5), (c == 6), (c == 1)};
      n_cmp++;
      if ({bus.if_stall, bus.if_ready, bus.mem_en} !== exp) begin
        n_err++;
        $display("FAIL fetch_c%0d {stall,ready,en} got %b exp %b", c,
                 {bus.if_stall, bus.if_ready, bus.mem_en}, exp);
      end
      if (c == 1) begin
        n_cmp++;
        if ({bus.mem_wr, bus.mem_addr} !== {1'b0, 16'h0010}) begin
          n_err++;
          $display("FAIL fetch_cmd got wr=%b addr=%h exp wr=0 addr=0010", bus.mem_wr, bus.mem_addr);
        end
      end
      if (c == 6) begin
        n_cmp++;
        if (bus.if_rdata !== 16'hA123) begin
          n_err++;
          $display("FAIL fetch_rdata got %h exp a123", bus.if_rdata);
        end
        bus.if_req = 0;
      end
      tick();
    end
  endtask

  task automatic test_lw();
    logic [2:0] exp;
    for (int c = 0; c <= 6; c++) begin
      if (c == 0) begin bus.d_rd_en = 1; bus.d_addr = 16'h0200; end
      #1;
      exp = {(c <= 5), (c == 6), (c == 1)};
      n_cmp++;
      if ({bus.d_stall, bus.d_ready, bus.mem_en} !== exp) begin
        n_err++;
        $display("FAIL lw_c%0d {stall,ready,en} got %b exp %b", c,
                 {bus.d_stall, bus.d_ready, bus.mem_en}, exp);
      end
      if (c == 6) begin
        n_cmp++;
        if ({bus.d_rdata, bus.if_rdata} !== {16'hBEEF, 16'hA123}) begin
          n_err++;
          $display("FAIL lw_rdata got d=%h if=%h exp d=beef if=a123", bus.d_rdata, bus.if_rdata);
        end
        bus.d_rd_en = 0;
      end
      tick();
    end
  endtask

  task automatic test_sw();
    for (int c = 0; c <= 6; c++) begin
      if (c == 0) begin bus.d_wr_en = 1; bus.d_addr = 16'h0204; bus.d_wdata = 16'h1234; end
      #1;
      if (c == 1) begin
        n_cmp++;
        if ({bus.mem_en, bus.mem_wr, bus.mem_addr, bus.mem_wdata} !== {2'b11, 16'h0204, 16'h1234}) begin
          n_err++;
          $display("FAIL sw_cmd got en=%b wr=%b addr=%h wdata=%h exp 1 1 0204 1234",
                   bus.mem_en, bus.mem_wr, bus.mem_addr, bus.mem_wdata);
        end
      end
      n_cmp++;
      if (bus.d_ready !== (c == 6)) begin
        n_err++;
        $display("FAIL sw_ready_c%0d got %b exp %b", c, bus.d_ready, (c == 6));
      end
      if (c == 6) begin
        n_cmp++;
        if (bus.d_rdata !== 16'hBEEF) begin
          n_err++;
          $display("FAIL sw_rdata got %h exp beef", bus.d_rdata);
        end
        bus.d_wr_en = 0;
      end
      tick();
    end
  endtask

  task automatic test_contention();
    logic [4:0] exp;
    for (int c = 0; c <= 13; c++) begin
      if (c == 0) begin
        bus.if_req = 1; bus.if_addr = 16'h0030;
        bus.d_rd_en = 1; bus.d_addr = 16'h0300;
      end
      #1;
      exp = {(c <= 12), (c <= 5), (c == 13), (c == 6), (c == 1 || c == 8)};
      n_cmp++;
      if ({bus.if_stall, bus.d_stall, bus.if_ready, bus.d_ready, bus.mem_en} !== exp) begin
        n_err++;
        $display("FAIL contend_c%0d {ist,dst,irdy,drdy,en} got %b exp %b", c,
                 {bus.if_stall, bus.d_stall, bus.if_ready, bus.d_ready, bus.mem_en}, exp);
      end
      if (c == 1 || c == 8) begin
        n_cmp++;
        if (bus.mem_addr !== ((c == 1) ? 16'h0300 : 16'h0030)) begin
          n_err++;
          $display("FAIL contend_addr_c%0d got %h exp %h", c, bus.mem_addr,
                   (c == 1) ? 16'h0300 : 16'h0030);
        end
      end
      if (c == 6) begin
        n_cmp++;
        if (bus.d_rdata !== 16'h595A) begin
          n_err++;
          $display("FAIL contend_drdata got %h exp 595a", bus.d_rdata);
        end
        bus.d_rd_en = 0;
      end
      if (c == 13) begin
        n_cmp++;
        if (bus.if_rdata !== 16'h5A6A) begin
          n_err++;
          $display("FAIL contend_irdata got %h exp 5a6a", bus.if_rdata);
        end
        bus.if_req = 0;
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c <= 9; c++) begin
      if (c == 0) begin bus.if_req = 1; bus.if_addr = 16'h0040; end
      if (c == 3) begin rst_n = 0; bus.if_req = 0; end
      if (c == 5) rst_n = 1;
      #1;
      if (c == 3 || c == 4) begin
        n_cmp++;
        if ({bus.if_ready, bus.d_ready, bus.mem_en, bus.mem_wr, bus.if_stall, bus.d_stall,
             bus.mem_addr, bus.if_rdata, bus.d_rdata} !== 54'h0) begin
          n_err++;
          $display("FAIL rstmid_zero_c%0d got rdy=%b%b en=%b addr=%h ird=%h drd=%h exp all 0", c,
                   bus.if_ready, bus.d_ready, bus.mem_en, bus.mem_addr, bus.if_rdata, bus.d_rdata);
        end
      end
      if (c >= 5) begin
        n_cmp++;
        if ({bus.if_ready, bus.mem_en, bus.if_rdata} !== 18'h0) begin
          n_err++;
          $display("FAIL rstmid_quiet_c%0d got rdy=%b en=%b ird=%h exp 0 0 0000", c,
                   bus.if_ready, bus.mem_en, bus.if_rdata);
        end
      end
      tick();
    end
    for (int c = 0; c <= 6; c++) begin
      if (c == 0) begin bus.if_req = 1; bus.if_addr = 16'h0010; end
      #1;
      n_cmp++;
      if (bus.if_ready !== (c == 6)) begin
        n_err++;
        $display("FAIL rstmid_fresh_c%0d ready got %b exp %b", c, bus.if_ready, (c == 6));
      end
      if (c == 6) begin
        n_cmp++;
        if (bus.if_rdata !== 16'hA123) begin
          n_err++;
          $display("FAIL rstmid_fresh_rdata got %h exp a123", bus.if_rdata);
        end
        bus.if_req = 0;
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] got [4];
    logic [15:0] exp [4];
    int n_got;
    n_got = 0;
`ifdef ARB_STARVE_GUARD_EN
    exp[0] = 16'h0400; exp[1] = 16'h0404; exp[2] = 16'h0050; exp[3] = 16'h0408;
`else
    exp[0] = 16'h0400; exp[1] = 16'h0404; exp[2] = 16'h0408; exp[3] = 16'h040C;
`endif
    bus.if_req = 1; bus.if_addr = 16'h0050;
    bus.d_rd_en = 1; bus.d_addr = 16'h0400;
    for (int c = 0; c < 60 && n_got < 4; c++) begin
      #1;
      if (bus.mem_en) begin got[n_got] = bus.mem_addr; n_got++; end
      if (bus.d_ready) bus.d_addr = bus.d_addr + 16'h0004;
      if (bus.if_ready) bus.if_req = 0;
      tick();
    end
    bus.if_req = 0; bus.d_rd_en = 0;
    n_cmp++;
    if (n_got != 4) begin
      n_err++;
      $display("FAIL b2b_grant_count got %0d exp 4", n_got);
    end
    for (int i = 0; i < n_got; i++) begin
      n_cmp++;
      if (got[i] !== exp[i]) begin
        n_err++;
        $display("FAIL b2b_grant%0d addr got %h exp %h", i, got[i], exp[i]);
      end
    end
    for (int i = 0; i < 10; i++) tick();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    lat_cnt = 0;
    ret_val = 16'h0;
    test_reset();
    test_fetch();
    test_lw();
    test_sw();
    test_contention();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
